// File: rtl/pix_stream_pkg.sv
// rtl/pix_stream_pkg.sv - shared types and frame defaults for the pixel stream path
package pix_stream_pkg;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 360;
  localparam int PIX_W   = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} tx_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_marker_t;

endpackage

// File: rtl/pix_fifo2.sv
// rtl/pix_fifo2.sv - 2-entry register FIFO with occupancy count and flush
module pix_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, wr_en_i} - {1'b0, rd_en_i};
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // The read-issue throttle upstream guarantees these never fire.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(wr_en_i && !rd_en_i && count_q == 2'd2));
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(rd_en_i && count_q == 2'd0));

endmodule

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - reads one raster frame from memory and streams it with sof/eol/eof
module pixel_stream_tx #(
  parameter int WIDTH  = pix_stream_pkg::FRAME_W,
  parameter int HEIGHT = pix_stream_pkg::FRAME_H,
  parameter int PIX_W  = pix_stream_pkg::PIX_W,
  parameter int ADDR_W = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [PIX_W-1:0]  mem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [PIX_W-1:0]  pixel_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              eof_o
);
  import pix_stream_pkg::*;

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int XW   = $clog2(WIDTH + 1);
  localparam int YW   = $clog2(HEIGHT + 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic [1:0]        count;
  logic [PIX_W-1:0]  head;
  logic              pop, rd_en, last_rd;
  pix_marker_t       mk;

  assign valid_o = (count != 2'd0);
  assign pop     = valid_o && ready_i;
  assign last_rd = (rd_addr_q == ADDR_W'(NPIX - 1));

  // Count a read already in flight as occupied so the buffer can never overflow.
  assign rd_en = (state_q == RUN) &&
                 (({1'b0, count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    mk.sof = valid_o && (x_q == '0) && (y_q == '0);
    mk.eol = valid_o && (x_q == XW'(WIDTH - 1));
    mk.eof = mk.eol && (y_q == YW'(HEIGHT - 1));
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    x_d       = x_q;
    y_d       = y_q;
    done_d    = 1'b0;
    if (rd_en) rd_addr_d = rd_addr_q + ADDR_W'(1);
    if (pop) begin
      if (x_q == XW'(WIDTH - 1)) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d   = RUN;
        rd_addr_d = '0;
        x_d       = '0;
        y_d       = '0;
      end
      RUN:  if (rd_en && last_rd) state_d = DRAIN;
      DRAIN: if (pop && mk.eof) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        rd_addr_d = '0;
        x_d       = '0;
        y_d       = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d   = IDLE;
      rd_addr_d = '0;
      x_d       = '0;
      y_d       = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      done_q     <= done_d;
      inflight_q <= rd_en && !abort_i;
    end
  end

  pix_fifo2 #(.DW(PIX_W)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (abort_i),
    .wr_en_i   (inflight_q),
    .wr_data_i (mem_rdata_i),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count)
  );

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign mem_rd_en_o = rd_en;
  assign mem_addr_o  = rd_addr_q;
  assign pixel_o     = valid_o ? head : '0;
  assign sof_o       = mk.sof;
  assign eol_o       = mk.eol;
  assign eof_o       = mk.eof;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - randomized self-checking bench for pixel_stream_tx
module tb_pixel_stream_tx;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
  logic          busy, done, rd_en, valid, sof, eol, eof;
  logic [AW-1:0] addr;
  logic [7:0]    rdata, pixel;
  logic [7:0]    mem [N];

  logic          s1_start = 1'b0, s1_abort = 1'b0, s1_ready = 1'b1;
  logic          s1_busy, s1_done, s1_rd_en, s1_valid, s1_sof, s1_eol, s1_eof;
  logic [0:0]    s1_addr;
  logic [7:0]    s1_rdata, s1_pixel;

  pixel_stream_tx #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy), .done_o(done), .mem_rd_en_o(rd_en), .mem_addr_o(addr),
    .mem_rdata_i(rdata), .valid_o(valid), .ready_i(ready_i), .pixel_o(pixel),
    .sof_o(sof), .eol_o(eol), .eof_o(eof)
  );

  pixel_stream_tx #(.WIDTH(1), .HEIGHT(1), .PIX_W(8), .ADDR_W(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(s1_start), .abort_i(s1_abort),
    .busy_o(s1_busy), .done_o(s1_done), .mem_rd_en_o(s1_rd_en), .mem_addr_o(s1_addr),
    .mem_rdata_i(s1_rdata), .valid_o(s1_valid), .ready_i(s1_ready), .pixel_o(s1_pixel),
    .sof_o(s1_sof), .eol_o(s1_eol), .eof_o(s1_eof)
  );

  always @(posedge clk) begin
    if (rd_en) rdata <= (int'(addr) < N) ? mem[addr] : 8'h00;
    if (s1_rd_en) s1_rdata <= (s1_addr == 1'b0) ? 8'hA5 : 8'h00;
  end

  int   errors = 0, checks = 0;
  int   n_xfer, n_reads, n_done, first_rd, first_vld, last_x, done_at;
  bit   hold_prev;
  logic [7:0] hold_pix;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return (c % 3) == 0;
      2:       return $urandom_range(0, 1) == 1;
      3:       return c > 20;
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_model();
    n_xfer = 0; n_reads = 0; n_done = 0;
    first_rd = -1; first_vld = -1; last_x = -1; done_at = -1;
    hold_prev = 1'b0;
  endtask

  task automatic observe(input int c);
    if (hold_prev) begin
      check_eq("hold_valid", 32'(valid), 32'd1);
      check_eq("hold_pixel", 32'(pixel), 32'(hold_pix));
    end
    if (valid && first_vld < 0) first_vld = c;
    if (valid && ready_i) begin
      check_eq("xfer_in_range", 32'(n_xfer < N), 32'd1);
      if (n_xfer < N) begin
        check_eq("pixel", 32'(pixel), 32'(mem[n_xfer]));
        check_eq("markers", 32'({sof, eol, eof}),
                 32'({n_xfer == 0, (n_xfer % W) == W - 1, n_xfer == N - 1}));
      end
      n_xfer++;
      last_x = c;
    end
    if (rd_en) begin
      if (first_rd < 0) first_rd = c;
      n_reads++;
      check_eq("rd_addr", 32'(addr), 32'(n_reads - 1));
      check_eq("buffer_bound", 32'((n_reads - n_xfer) <= 2), 32'd1);
    end
    if (done) begin
      n_done++;
      if (done_at < 0) done_at = c;
      check_eq("busy_at_done", 32'(busy), 32'd0);
    end
    hold_prev = valid && !ready_i;
    hold_pix  = pixel;
  endtask

  // pre: the start edge already happened (chained start in the done cycle)
  task automatic run_frame(input int mode, input bit pre, input bit chain);
    int c;
    bit eof_seen;
    clear_model();
    c = pre ? 1 : 0;
    start_i = !pre;
    abort_i = 1'b0;
    ready_i = ready_for(mode, c);
    while (c < 300 && done_at < 0) begin
      @(negedge clk);
      observe(c);
      if (mode == 3 && c == 20) begin
        check_eq("stall_reads", 32'(n_reads), 32'd2);
        check_eq("stall_valid", 32'(valid), 32'd1);
        check_eq("stall_pixel", 32'(pixel), 32'(mem[0]));
      end
      eof_seen = valid && ready_i && eof;
      @(posedge clk);
      #1;
      c++;
      start_i = (mode == 1 && c == 8) || (chain && eof_seen);
      ready_i = ready_for(mode, c);
    end
    check_eq("done_seen", 32'(done_at >= 0), 32'd1);
    check_eq("xfer_total", 32'(n_xfer), 32'(N));
    check_eq("done_after_last", 32'(done_at), 32'(last_x + 1));
    if (mode == 0) begin
      check_eq("first_read_cycle", 32'(first_rd), 32'd1);
      check_eq("first_valid_cycle", 32'(first_vld), 32'd3);
      check_eq("no_bubbles", 32'(last_x - first_vld), 32'(N - 1));
    end
    if (!chain) begin
      repeat (3) begin
        @(negedge clk);
        check_eq("idle_done", 32'(done), 32'd0);
        check_eq("idle_valid", 32'(valid), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_until_xfers(input int k);
    int c = 0;
    clear_model();
    start_i = 1'b1;
    ready_i = 1'b1;
    while (n_xfer < k && c < 50) begin
      @(negedge clk);
      observe(c);
      @(posedge clk);
      #1;
      c++;
      start_i = 1'b0;
    end
    check_eq("pre_xfers", 32'(n_xfer), 32'(k));
  endtask

  task automatic abort_test();
    run_until_xfers(5);
    abort_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check_eq("abort_valid", 32'(valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (5) begin
      check_eq("abort_no_done", 32'(done), 32'd0);
      check_eq("abort_stays_idle", 32'(valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({busy, done, rd_en, valid, sof, eol, eof}), 32'd0);
    check_eq(tag, 32'(addr), 32'd0);
    check_eq(tag, 32'(pixel), 32'd0);
  endtask

  task automatic reset_test();
    run_until_xfers(3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_frame");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tiny_test();
    int x1 = 0, d1 = 0;
    s1_start = 1'b1;
    s1_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s1_valid && s1_ready) begin
        x1++;
        check_eq("tiny_pixel", 32'(s1_pixel), 32'hA5);
        check_eq("tiny_markers", 32'({s1_sof, s1_eol, s1_eof}), 32'b111);
      end
      if (s1_done) begin
        d1++;
        check_eq("tiny_done_after_xfer", 32'(x1), 32'd1);
        check_eq("tiny_busy_at_done", 32'(s1_busy), 32'd0);
      end
      @(posedge clk);
      #1;
      s1_start = 1'b0;
    end
    check_eq("tiny_xfers", 32'(x1), 32'd1);
    check_eq("tiny_done", 32'(d1), 32'd1);
  endtask

  task automatic fill_random();
    for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem[a] = 8'(a);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    run_frame(0, 1'b0, 1'b1);
    fill_random();
    run_frame(0, 1'b1, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(3, 1'b0, 1'b0);
    repeat (3) begin
      fill_random();
      run_frame(2, 1'b0, 1'b0);
    end
    abort_test();
    run_frame(0, 1'b0, 1'b0);
    reset_test();
    run_frame(2, 1'b0, 1'b0);
    tiny_test();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
